hwpe_dma_loader: RTL
====================

Name: hwpe_dma_loader

Overview:
- Upstream feeder for the hwpe DMA write port (dma_wen/dma_wa/dma_wd).
- Takes a command (destination SRAM address, length in 64-bit beats) and consumes a 32-bit valid/ready source stream.
- Packs pairs of source words into 64-bit little-endian beats and writes each beat to consecutive 8-byte-spaced addresses.
- Replaces bench-driven fmap/kernel loading, so FMEM/KMEM loads become command-driven.

Parameters:
- ADDR_WIDTH, 16: width of dma_wa; must equal HWPE_ADDR_WIDTH.
- LEN_WIDTH, 16: width of the beat count in a command.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  loader idle, command accepted when valid&ready
- cmd_dst_addr  in  ADDR_WIDTH  first destination byte address (8-byte aligned)
- cmd_len  in  LEN_WIDTH  number of 64-bit beats to write
- src_valid  in  1  source word valid
- src_ready  out  1  loader accepts source word
- src_data  in  32  source word
- dma_wen  out  1  write strobe to hwpe
- dma_wa  out  ADDR_WIDTH  write address
- dma_wd  out  64  write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command complete

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, then 1. All other outputs are 0: src_ready, dma_wen, dma_wa, dma_wd, busy, done. State is IDLE.
- FSM states: IDLE, FILL_LO, FILL_HI.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch dst=cmd_dst_addr, remaining=cmd_len, set busy=1.
  - If cmd_len==0: go to IDLE, assert done the next cycle, busy returns to 0 with done, no writes.
  - Otherwise go to FILL_LO.
- FILL_LO:
  - src_ready=1.
  - On src_valid: lo<=src_data, go to FILL_HI.
- FILL_HI:
  - src_ready=1.
  - On src_valid, in the next cycle: dma_wen=1, dma_wa=dst, dma_wd={src_data, lo}.
  - dst<=dst+8, wrapping modulo 2^ADDR_WIDTH.
  - remaining<=remaining-1.
  - If remaining was 1: go to IDLE, and in that same next cycle done=1 and busy=0 (done coincides with the final dma_wen). Otherwise go to FILL_LO.
- Latency:
  - The high-word acceptance edge is followed by the dma_wen cycle; dma_wen is registered and high for exactly one cycle per beat.
  - Peak throughput is one beat per 2 cycles; source stalls insert idle cycles.
- Between writes: dma_wen=0; dma_wa and dma_wd hold their last values.
- cmd_ready is 0 whenever busy=1. Commands offered while busy are ignored, not queued.
- Simultaneous events:
  - A final-beat write and a new cmd_valid in the same cycle: the new command is taken only when the FSM is in IDLE, i.e. the cycle after done.
- Source words presented in IDLE are not consumed (src_ready=0).
- Reset mid-operation: FSM returns to IDLE, any half-packed word is discarded, no dma_wen is issued, done is not pulsed.
- Misaligned cmd_dst_addr: the low 3 bits are forced to 0 on latch.

Optional Feature:
- Macro: HWPE_DMA_LOADER_BSWAP_EN.
- Defined: each 32-bit src_data word is byte-reversed before packing, for big-endian sources. Example: 0x11223344 becomes 0x44332211.
- Undefined: words are packed unchanged.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package:
  - State encoding (IDLE=2'd0, FILL_LO=2'd1, FILL_HI=2'd2).
  - BEAT_BYTES=8.
  - ADDR_WIDTH default tied to HWPE_ADDR_WIDTH in hwpe_define.vh.
- One natural sub-module: hwpe_dma_pack32to64, the lo/hi register plus optional byte swap, producing a valid beat.
- The FSM and counters stay in the top.

Test Plan:
- Reset, then cmd dst=0x0000 len=2; src words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with no stalls -> two writes: wa=0x0000 wd=0x0706050403020100, then wa=0x0008 wd=0x0F0E0D0C0B0A0908. done pulses with the second write; writes are 2 cycles apart.
- cmd len=0 -> no dma_wen; done=1 exactly one cycle after acceptance; cmd_ready back to 1.
- cmd dst=0xFFF8 len=2 -> writes at wa=0xFFF8 then wa=0x0000 (wrap).
- src_valid toggling 1,0,0,1 during one beat -> single write only after the second accepted word; dma_wen stays 0 during stalls.
- Assert rst after the low word of beat 1 of a len=4 command -> no write, no done; the next command dst=0x0100 len=1 writes only freshly supplied words.
- With HWPE_DMA_LOADER_BSWAP_EN: words 0x11223344, 0x55667788 -> wd=0x8877665544332211.

Source files
------------

// File: rtl/hwpe_dma_loader_pkg.sv
// ---------------------------------------------------------------------------
// hwpe_dma_loader_pkg
// Shared definitions for the hwpe DMA loader: FSM state encoding, beat size,
// default write-port address width and the byte-swap helper used by the
// packer when HWPE_DMA_LOADER_BSWAP_EN is defined.
// ---------------------------------------------------------------------------
package hwpe_dma_loader_pkg;

   // Mirrors HWPE_ADDR_WIDTH from hwpe_define.vh; keep the two in step so
   // dma_wa matches the hwpe write port width.
   localparam int HWPE_ADDR_WIDTH = 16;

   // One destination beat is 64 bits, i.e. 8 bytes of SRAM address space.
   localparam int BEAT_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL_LO = 2'd1,
      FILL_HI = 2'd2
   } loader_state_e;

   // Reverse byte order of a 32-bit word (big-endian source support).
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/hwpe_dma_pack32to64.sv
// ---------------------------------------------------------------------------
// hwpe_dma_pack32to64
// Packs two 32-bit source words into one 64-bit little-endian beat. The low
// word is held in a register; the beat is formed combinationally from the
// held low word and the incoming high word so the caller can register it in
// the same cycle the high word is accepted.
//
// Optional build macro: HWPE_DMA_LOADER_BSWAP_EN -- when defined every source
// word is byte-reversed before packing (big-endian sources).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   lo_en        capture word as the low half of the beat
//   hi_en        word is the high half; beat_data is valid this cycle
//   word         32-bit source word
//   beat_valid   high when beat_data holds a complete beat
//   beat_data    {high word, low word}
// ---------------------------------------------------------------------------
module hwpe_dma_pack32to64
   import hwpe_dma_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        lo_en,
   input  logic        hi_en,
   input  logic [31:0] word,
   output logic        beat_valid,
   output logic [63:0] beat_data
);

   logic [31:0] word_sw;
   logic [31:0] lo_q;
   logic [31:0] lo_d;

`ifdef HWPE_DMA_LOADER_BSWAP_EN
   assign word_sw = bswap32(word);
`else
   assign word_sw = word;
`endif

   always_comb begin
      lo_d = lo_q;
      if (lo_en) begin
         lo_d = word_sw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q <= '0;
      end else begin
         lo_q <= lo_d;
      end
   end

   assign beat_valid = hi_en;
   assign beat_data  = {word_sw, lo_q};

endmodule

// File: rtl/hwpe_dma_loader.sv
// ---------------------------------------------------------------------------
// hwpe_dma_loader
// Command-driven feeder for the hwpe DMA write port. A command gives an
// 8-byte aligned destination address and a length in 64-bit beats; the
// loader then consumes 2*len words from a 32-bit valid/ready stream, packs
// word pairs little-endian and writes each beat to consecutive 8-byte
// addresses (wrapping modulo 2^ADDR_WIDTH). All outputs are registered.
//
// Optional build macro: HWPE_DMA_LOADER_BSWAP_EN (byte-reverse source words,
// handled inside hwpe_dma_pack32to64; timing is unchanged).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_dst_addr, cmd_len         first byte address, beat count
//   src_valid/src_ready/src_data  32-bit source stream
//   dma_wen, dma_wa, dma_wd       registered write to the hwpe SRAM port
//   busy                          command in progress
//   done                          one-cycle completion pulse
// ---------------------------------------------------------------------------
module hwpe_dma_loader
   import hwpe_dma_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = HWPE_ADDR_WIDTH,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [31:0]           src_data,
   output logic                  dma_wen,
   output logic [ADDR_WIDTH-1:0] dma_wa,
   output logic [63:0]           dma_wd,
   output logic                  busy,
   output logic                  done
);

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  zero_pend_q, zero_pend_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  src_ready_q, src_ready_d;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] wa_q, wa_d;
   logic [63:0]           wd_q, wd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  src_fire;
   logic                  lo_en;
   logic                  hi_en;
   logic                  beat_valid;
   logic [63:0]           beat_data;

   assign src_fire = src_valid && src_ready_q;
   assign lo_en    = src_fire && (state_q == FILL_LO);
   assign hi_en    = src_fire && (state_q == FILL_HI);

   hwpe_dma_pack32to64 u_pack (
      .clk        (clk),
      .rst        (rst),
      .lo_en      (lo_en),
      .hi_en      (hi_en),
      .word       (src_data),
      .beat_valid (beat_valid),
      .beat_data  (beat_data)
   );

   always_comb begin
      state_d     = state_q;
      dst_d       = dst_q;
      rem_d       = rem_q;
      zero_pend_d = 1'b0;
      wen_d       = 1'b0;
      wa_d        = wa_q;
      wd_d        = wd_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (zero_pend_q) begin
               // Zero-length command: finish one cycle after acceptance.
               done_d = 1'b1;
               busy_d = 1'b0;
            end else if (cmd_valid && cmd_ready_q) begin
               // Misaligned addresses are silently rounded down to a beat.
               dst_d  = cmd_dst_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
               rem_d  = cmd_len;
               busy_d = 1'b1;
               if (cmd_len == '0) begin
                  zero_pend_d = 1'b1;
               end else begin
                  state_d = FILL_LO;
               end
            end
         end
         FILL_LO: begin
            if (lo_en) begin
               state_d = FILL_HI;
            end
         end
         FILL_HI: begin
            if (beat_valid) begin
               wen_d = 1'b1;
               wa_d  = dst_q;
               wd_d  = beat_data;
               dst_d = dst_q + ADDR_WIDTH'(BEAT_BYTES);
               rem_d = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) begin
                  // Final beat: done and busy-drop line up with the write.
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = FILL_LO;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      cmd_ready_d = !busy_d;
      src_ready_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         dst_q       <= '0;
         rem_q       <= '0;
         zero_pend_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         src_ready_q <= 1'b0;
         wen_q       <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dst_q       <= dst_d;
         rem_q       <= rem_d;
         zero_pend_q <= zero_pend_d;
         cmd_ready_q <= cmd_ready_d;
         src_ready_q <= src_ready_d;
         wen_q       <= wen_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign src_ready = src_ready_q;
   assign dma_wen   = wen_q;
   assign dma_wa    = wa_q;
   assign dma_wd    = wd_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
